pipelined_adder_tree_ir: RTL and testbench

//  N-input pipelined adder/subtractor tree: successor to the 2-input registered adder, generalised in input count.

---
 rtl/pipelined_adder_tree_ir.sv | 73 +++++++
 tb/tb_pipelined_adder_tree_ir.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_tree_ir.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipelined_adder_tree_ir                                                  |
// | N-input pipelined signed adder/subtractor tree, log2(N) registered levels|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipelined_adder_tree_ir #(
  parameter int IN_WIDTH   = 10,
  parameter int NUM_INPUTS = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      enable,
  input  logic                                      inReady,
  input  logic [NUM_INPUTS*IN_WIDTH-1:0]            inBus,
  input  logic [NUM_INPUTS-1:0]                     subMask,
  output logic                                      earlyOutReady,
  output logic                                      outReady,
  output logic signed [IN_WIDTH+$clog2(NUM_INPUTS):0] out
);

  localparam int LOG2N     = $clog2(NUM_INPUTS);
  localparam int OUT_WIDTH = IN_WIDTH + LOG2N + 1;

  // Heap-ordered tree: node i = node 2i + node 2i+1; leaves at N..2N-1, root (i=1) is out.
  // Every node is carried at full result width, so no level can overflow.
  logic signed [OUT_WIDTH-1:0] r_node [2:2*NUM_INPUTS-1];
  logic signed [OUT_WIDTH-1:0] w_leaf [NUM_INPUTS];
  logic        [LOG2N:0]       r_v;

  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_leaf
    assign w_leaf[k] = subMask[k] ? -OUT_WIDTH'($signed(inBus[k*IN_WIDTH +: IN_WIDTH]))
                                  :  OUT_WIDTH'($signed(inBus[k*IN_WIDTH +: IN_WIDTH]));

    always_ff @(posedge clk) begin
      if (enable && inReady && !reset) begin
        r_node[NUM_INPUTS+k] <= w_leaf[k];
      end
    end
  end

  for (genvar i = 2; i < NUM_INPUTS; i++) begin : g_node
    // Tree level of node i, counted upward from the leaves (level 0).
    localparam int LV = LOG2N + 1 - $clog2(i + 1);

    always_ff @(posedge clk) begin
      if (enable && r_v[LV-1]) begin
        r_node[i] <= r_node[2*i] + r_node[2*i+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (enable && r_v[LOG2N-1]) begin
      out <= r_node[2] + r_node[3];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v <= '0;
    end else if (enable) begin
      r_v <= {r_v[LOG2N-1:0], inReady};
    end
  end

  assign outReady      = r_v[LOG2N];
  assign earlyOutReady = r_v[LOG2N-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder_tree_ir.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipelined_adder_tree_ir                                               |
// | Vector table + scoreboard bench for the 8-input tree and a 2-input build |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pipelined_adder_tree_ir;

  localparam int W  = 10;
  localparam int N  = 8;
  localparam int LG = 3;

  typedef struct {
    logic [N*W-1:0] bus;
    logic [N-1:0]   mask;
    int             exp;
  } vec_t;

  typedef struct {
    int val;
    int due;
  } sb_t;

  logic clk = 1'b0;
  logic reset, enable, inReady, inReady2;
  logic [N*W-1:0] inBus;
  logic [N-1:0]   subMask;
  logic [2*W-1:0] inBus2;
  logic [1:0]     subMask2;
  logic early, ordy, early2, ordy2;
  logic signed [W+LG:0] out8;
  logic signed [W+1:0]  out2;

  int   n_vec = 0;
  int   n_err = 0;
  int   en_cnt = 0;
  logic last_en = 1'b0;
  logic last_rst = 1'b0;
  int   exp_out = 0;
  logic exp_ordy = 1'b0;
  logic exp_early = 1'b0;
  sb_t  sb[$];
  vec_t vecs[12];

  pipelined_adder_tree_ir #(.IN_WIDTH(W), .NUM_INPUTS(N)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .inReady(inReady),
    .inBus(inBus), .subMask(subMask),
    .earlyOutReady(early), .outReady(ordy), .out(out8)
  );

  pipelined_adder_tree_ir #(.IN_WIDTH(W), .NUM_INPUTS(2)) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable), .inReady(inReady2),
    .inBus(inBus2), .subMask(subMask2),
    .earlyOutReady(early2), .outReady(ordy2), .out(out2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model(input logic [N*W-1:0] bus, input logic [N-1:0] mask);
    int s = 0;
    for (int k = 0; k < N; k++) begin
      int v = int'($signed(bus[k*W +: W]));
      s += mask[k] ? -v : v;
    end
    return s;
  endfunction

  always @(posedge clk) begin
    last_en  <= enable;
    last_rst <= reset;
    if (enable && !reset) en_cnt <= en_cnt + 1;
  end

  // Scoreboard monitor: sampled mid-cycle, due times counted in enabled edges.
  always @(negedge clk) begin
    if (last_rst) begin
      chk("rst_out", out8, 0);
      chk("rst_outReady", ordy, 0);
      chk("rst_early", early, 0);
      exp_out = 0; exp_ordy = 1'b0; exp_early = 1'b0;
    end else if (last_en) begin
      exp_ordy = 1'b0;
      if (sb.size() > 0 && sb[0].due == en_cnt) begin
        exp_ordy = 1'b1;
        exp_out  = sb[0].val;
        void'(sb.pop_front());
      end
      exp_early = 1'b0;
      foreach (sb[i]) if (sb[i].due == en_cnt + 1) exp_early = 1'b1;
      chk("outReady", ordy, exp_ordy);
      chk("out", out8, exp_out);
      chk("earlyOutReady", early, exp_early);
    end else begin
      chk("stall_outReady", ordy, exp_ordy);
      chk("stall_out", out8, exp_out);
      chk("stall_early", early, exp_early);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [N*W-1:0] bus, input logic [N-1:0] mask, input int exp);
    sb_t e;
    inBus   = bus;
    subMask = mask;
    inReady = 1'b1;
    e.val = exp;
    e.due = en_cnt + 1 + LG;
    sb.push_back(e);
    tick();
  endtask

  function automatic logic [N*W-1:0] rep(input logic [W-1:0] v);
    return {N{v}};
  endfunction

  initial begin
    logic [N*W-1:0] ramp;
    for (int k = 0; k < N; k++) ramp[k*W +: W] = W'(k);

    vecs[0] = '{rep(10'd1),   8'h00, 8};
    vecs[1] = '{rep(10'h200), 8'hFF, 4096};
    vecs[2] = '{rep(10'h200), 8'h00, -4096};
    vecs[3] = '{ramp,         8'hAA, -4};
    vecs[4] = '{rep(10'h1FF), 8'h00, 4088};
    vecs[5] = '{{4{10'h200, 10'h1FF}}, 8'h55, -4092};
    for (int i = 6; i < 12; i++) begin
      vecs[i].bus  = {$urandom, $urandom, $urandom};
      vecs[i].mask = 8'($urandom);
      vecs[i].exp  = model(vecs[i].bus, vecs[i].mask);
    end

    reset = 1'b1; enable = 1'b1; inReady = 1'b0; inReady2 = 1'b0;
    inBus = '0; subMask = '0; inBus2 = '0; subMask2 = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_out2", out2, 0);
    chk("rst_outReady2", ordy2, 0);
    tick();

    // Single set of ones: early after 2 edges, result 8 after 3, then held.
    send(rep(10'd1), 8'h00, 8);
    inReady = 1'b0;
    tick();
    tick();
    chk("t1_early", early, 1);
    chk("t1_ordy_pre", ordy, 0);
    tick();
    chk("t1_ordy", ordy, 1);
    chk("t1_out", out8, 8);
    tick();
    chk("t1_ordy_post", ordy, 0);
    chk("t1_out_hold", out8, 8);

    // Vector table, applied back to back.
    for (int i = 0; i < 12; i++) send(vecs[i].bus, vecs[i].mask, vecs[i].exp);
    inReady = 1'b0;
    repeat (5) tick();

    // Four consecutive ramp sets with alternating subtract.
    repeat (4) send(ramp, 8'hAA, -4);
    inReady = 1'b0;
    repeat (5) tick();

    // Two-cycle stall while two sets are in flight.
    send(rep(10'd5), 8'h00, 40);
    send(rep(10'd5), 8'h00, 40);
    inReady = 1'b0;
    enable  = 1'b0;
    tick(); tick();
    enable  = 1'b1;
    repeat (6) tick();

    // Reset one edge after acceptance; the colliding new set must also be dropped.
    send(rep(10'd1), 8'h00, 8);
    reset = 1'b1;
    inBus = rep(10'd3);
    sb.delete();
    tick();
    reset   = 1'b0;
    inReady = 1'b0;
    repeat (6) tick();

    // 2-input build: legacy one-edge latency.
    inBus2 = {10'h3F9, 10'd3}; subMask2 = 2'b00; inReady2 = 1'b1;
    tick();
    inReady2 = 1'b0;
    chk("n2_early", early2, 1);
    chk("n2_ordy_pre", ordy2, 0);
    tick();
    chk("n2_ordy", ordy2, 1);
    chk("n2_out", out2, -4);
    chk("n2_early_post", early2, 0);
    tick();
    chk("n2_ordy_post", ordy2, 0);
    chk("n2_out_hold", out2, -4);
    subMask2 = 2'b10; inReady2 = 1'b1;
    tick();
    inReady2 = 1'b0;
    tick();
    chk("n2_sub_out", out2, 10);

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
